// File: rtl/exception_ctrl_pkg.sv
// Shared types and encodings for the LEGv8 exception unit: FSM states,
// ESR cause codes and MRS system-register select values.
package exc_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    TAKEN   = 2'd1,
    HANDLER = 2'd2,
    FAULT   = 2'd3
  } exc_state_t;

  localparam logic [3:0] ESR_INVALID = 4'b0001;
  localparam logic [3:0] ESR_IRQ     = 4'b0010;

  localparam logic [1:0] SEL_ELR    = 2'b00;
  localparam logic [1:0] SEL_ESR    = 2'b01;
  localparam logic [1:0] SEL_STATUS = 2'b10;
  localparam logic [1:0] SEL_ZERO   = 2'b11;

endpackage

// File: rtl/exception_ctrl_irq_sync.sv
// Two-flop synchronizer for the external interrupt line; both flops clear
// on reset so a stale request cannot survive it.
module irq_sync (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/exception_ctrl.sv
// LEGv8 exception unit: captures ELR/ESR, redirects the PC to the vector,
// tracks handler state and serves MRS reads. IRQ_SYNC_EN adds an ExtIRQ synchronizer.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned       N          = 64,
  parameter logic [N-1:0]      EXC_VECTOR = 64'h00000000000000D8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         NotAnInstr,
  input  logic         ERet,
  input  logic         ExtIRQ,
  input  logic [N-1:0] PC_in,
  input  logic [1:0]   SysRegSel,
  output logic         Exc,
  output logic [N-1:0] ExcVector,
  output logic [N-1:0] ERetPC,
  output logic [N-1:0] SysRegData,
  output logic         ExtIAck,
  output logic         InHandler,
  output logic         Halt
);

  exc_state_t   state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic         cause_irq_q, cause_irq_d;
  logic         exc_q, exc_d;
  logic         iack_q, iack_d;
  logic         halt_q, halt_d;
  logic         irq_det;

`ifdef IRQ_SYNC_EN
  irq_sync u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (ExtIRQ),
    .q_o   (irq_det)
  );
`else
  assign irq_det = ExtIRQ;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= NORMAL;
      elr_q       <= '0;
      esr_q       <= '0;
      cause_irq_q <= 1'b0;
      exc_q       <= 1'b0;
      iack_q      <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elr_q       <= elr_d;
      esr_q       <= esr_d;
      cause_irq_q <= cause_irq_d;
      exc_q       <= exc_d;
      iack_q      <= iack_d;
      halt_q      <= halt_d;
    end
  end

  // Exc and ExtIAck are one-cycle strobes registered on the transition edge.
  always_comb begin
    state_d     = state_q;
    elr_d       = elr_q;
    esr_d       = esr_q;
    cause_irq_d = cause_irq_q;
    exc_d       = 1'b0;
    iack_d      = 1'b0;
    halt_d      = halt_q;
    case (state_q)
      NORMAL: begin
        if (NotAnInstr) begin
          elr_d       = PC_in;
          esr_d       = ESR_INVALID;
          cause_irq_d = 1'b0;
          exc_d       = 1'b1;
          state_d     = TAKEN;
        end else if (irq_det) begin
          elr_d       = PC_in;
          esr_d       = ESR_IRQ;
          cause_irq_d = 1'b1;
          exc_d       = 1'b1;
          state_d     = TAKEN;
        end
      end
      TAKEN:   state_d = HANDLER;
      HANDLER: begin
        if (NotAnInstr) begin
          state_d = FAULT;
          halt_d  = 1'b1;
        end else if (ERet) begin
          state_d = NORMAL;
          iack_d  = cause_irq_q;
        end
      end
      FAULT:   halt_d = 1'b1;
      default: state_d = NORMAL;
    endcase
  end

  assign Exc       = exc_q;
  assign ExtIAck   = iack_q;
  assign Halt      = halt_q;
  assign InHandler = (state_q == TAKEN) || (state_q == HANDLER);
  assign ExcVector = EXC_VECTOR;
  assign ERetPC    = elr_q;

  always_comb begin
    SysRegData = '0;
    case (SysRegSel)
      SEL_ELR:    SysRegData = elr_q;
      SEL_ESR:    SysRegData = {{(N-4){1'b0}}, esr_q};
      SEL_STATUS: SysRegData = {{(N-2){1'b0}}, halt_q, InHandler};
      SEL_ZERO:   SysRegData = '0;
      default:    SysRegData = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed scoreboard bench for exception_ctrl: expected values are queued
// with each stimulus step and popped as the DUT outputs are sampled.
module tb_exception_ctrl;

  localparam int N = 64;
`ifdef IRQ_SYNC_EN
  localparam int IRQ_LAT = 3;
`else
  localparam int IRQ_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         NotAnInstr, ERet, ExtIRQ;
  logic [N-1:0] PC_in;
  logic [1:0]   SysRegSel;
  logic         Exc, ExtIAck, InHandler, Halt;
  logic [N-1:0] ExcVector, ERetPC, SysRegData;

  exception_ctrl #(.N(N), .EXC_VECTOR(64'hD8)) dut (
    .clk        (clk),
    .reset      (reset),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .ExtIRQ     (ExtIRQ),
    .PC_in      (PC_in),
    .SysRegSel  (SysRegSel),
    .Exc        (Exc),
    .ExcVector  (ExcVector),
    .ERetPC     (ERetPC),
    .SysRegData (SysRegData),
    .ExtIAck    (ExtIAck),
    .InHandler  (InHandler),
    .Halt       (Halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [N-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   assertions = 0;
  int   failures   = 0;

  task automatic push(input string tag, input logic [N-1:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [N-1:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: observed %h expected <queued value>", obs);
      return;
    end
    e = sb.pop_front();
    assertions++;
    assert (obs === e.val) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic rd(input logic [1:0] sel, output logic [N-1:0] obs);
    SysRegSel = sel;
    #1;
    obs = SysRegData;
  endtask

  // Advance one edge; outputs are then stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] r;
    reset = 1'b1; NotAnInstr = 1'b0; ERet = 1'b0; ExtIRQ = 1'b0;
    PC_in = '0; SysRegSel = 2'b00;
    #2;
    push("rst_exc", 0); push("rst_halt", 0); push("rst_inh", 0);
    push("rst_iack", 0); push("rst_elr", 0); push("rst_vec", 64'hD8);
    chk(Exc); chk(Halt); chk(InHandler); chk(ExtIAck);
    rd(2'b00, r); chk(r); chk(ExcVector);
    tick(); reset = 1'b0;

    // invalid opcode
    PC_in = 64'h40; NotAnInstr = 1'b1;
    push("inv_exc", 1); push("inv_vec", 64'hD8); push("inv_elr", 64'h40);
    push("inv_esr", 1); push("inv_inh", 1);
    tick(); NotAnInstr = 1'b0;
    chk(Exc); chk(ExcVector); rd(2'b00, r); chk(r); rd(2'b01, r); chk(r); chk(InHandler);
    push("inv_exc_1cyc", 0); push("inv_inh_h", 1);
    tick(); chk(Exc); chk(InHandler);
    ERet = 1'b1;
    push("inv_noack", 0); push("inv_ret_inh", 0);
    tick(); ERet = 1'b0; chk(ExtIAck); chk(InHandler);

    // interrupt and return
    PC_in = 64'h100; ExtIRQ = 1'b1;
    for (int i = 0; i < IRQ_LAT - 1; i++) begin
      push("irq_lat_wait", 0); tick(); chk(Exc);
    end
    push("irq_exc", 1); push("irq_esr", 2);
    tick(); ExtIRQ = 1'b0; PC_in = 64'h200;
    chk(Exc); rd(2'b01, r); chk(r);
    for (int i = 0; i < 3; i++) begin
      push("irq_hnd_exc", 0); tick(); chk(Exc);
    end
    push("irq_eretpc", 64'h100);
    chk(ERetPC);
    ERet = 1'b1;
    push("irq_ack", 1); push("irq_ret_inh", 0);
    tick(); ERet = 1'b0; chk(ExtIAck); chk(InHandler);
    push("irq_ack_1cyc", 0); push("irq_no_retake", 0);
    tick(); chk(ExtIAck); chk(Exc);

    // priority: invalid beats irq
    PC_in = 64'h20; NotAnInstr = 1'b1; ExtIRQ = 1'b1;
    push("pri_exc", 1); push("pri_esr", 1); push("pri_elr", 64'h20);
    tick(); NotAnInstr = 1'b0; ExtIRQ = 1'b0;
    chk(Exc); rd(2'b01, r); chk(r); rd(2'b00, r); chk(r);
    for (int i = 0; i < 3; i++) tick();
    ERet = 1'b1;
    push("pri_noack", 0);
    tick(); ERet = 1'b0; chk(ExtIAck);
    push("pri_idle_exc", 0); tick(); chk(Exc);

    // masking and double fault
    PC_in = 64'h60; NotAnInstr = 1'b1;
    tick(); NotAnInstr = 1'b0;
    tick();
    ExtIRQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("mask_exc", 0); push("mask_inh", 1);
      tick(); chk(Exc); chk(InHandler);
    end
    NotAnInstr = 1'b1; PC_in = 64'h70;
    push("df_halt", 1); push("df_exc", 0); push("df_status", 64'h2);
    push("df_elr", 64'h60); push("df_esr", 1);
    tick(); NotAnInstr = 1'b0;
    chk(Halt); chk(Exc); rd(2'b10, r); chk(r); rd(2'b00, r); chk(r); rd(2'b01, r); chk(r);
    ERet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push("df_sticky_halt", 1); push("df_sticky_exc", 0); push("df_sticky_ack", 0);
      tick(); chk(Halt); chk(Exc); chk(ExtIAck);
      ERet = 1'b0;
    end
    push("zero_sel", 0); rd(2'b11, r); chk(r);
    ExtIRQ = 1'b0;

    // async reset mid-operation
    reset = 1'b1; #1;
    push("rst2_halt", 0); chk(Halt);
    reset = 1'b0;
    tick();
    PC_in = 64'h80; NotAnInstr = 1'b1;
    push("rst3_exc_pre", 1);
    tick(); NotAnInstr = 1'b0; chk(Exc);
    reset = 1'b1; #1;
    push("arst_exc", 0); push("arst_elr", 0); push("arst_esr", 0);
    push("arst_halt", 0); push("arst_inh", 0);
    chk(Exc); rd(2'b00, r); chk(r); rd(2'b01, r); chk(r); chk(Halt); chk(InHandler);
    tick(); reset = 1'b0;
    ERet = 1'b1;
    push("eret_norm_inh", 0); push("eret_norm_exc", 0); push("eret_norm_ack", 0);
    tick(); ERet = 1'b0; chk(InHandler); chk(Exc); chk(ExtIAck);
    push("eret_norm_exc2", 0); push("eret_norm_elr", 0);
    tick(); chk(Exc); chk(ERetPC);

    if (sb.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
